// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with valid/ready handshake, one-entry skid buffer and flush.
module pipe_skid_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, next;
  logic [WIDTH-1:0] main_q, skid_q;
  logic it, ot;
  assign it = in_valid & in_ready;
  assign ot = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= flush ? EMPTY : next;
  end
  always_comb begin
    next = state == EMPTY ? (it ? ONE : EMPTY) :
           state == ONE   ? (it && !ot ? FULL : !it && ot ? EMPTY : ONE) :
           state == FULL  ? (ot ? ONE : FULL) : EMPTY;
  end
  always_comb begin
    in_ready  = state != FULL;
    out_valid = state != EMPTY;
    occupancy = state;
    out_data  = main_q;
  end
  // Main only ever takes input when it is (or is becoming) the oldest entry; skid refills main in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else if (flush) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if ((state == EMPTY && it) || (state == ONE && it && ot)) main_q <= in_data;
      else if (state == FULL && ot) main_q <= skid_q;
      if (state == ONE && it && !ot) skid_q <= in_data;
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and randomized checks of pipe_skid_reg against a queue-based model.
module tb_pipe_skid_reg;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] in_data = '0, out_data;
  logic [1:0] occupancy;
  logic [31:0] q[$];
  logic [31:0] last = RV;
  int checks = 0, failures = 0;

  pipe_skid_reg #(.WIDTH(32), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("occupancy", {30'd0, occupancy}, q.size());
    chk("out_data", out_data, q.size() > 0 ? q[0] : last);
  endtask

  // Drive at the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
    bit pop, push;
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(posedge clk);
    if (f) begin
      q.delete();
      last = RV;
    end else begin
      pop = r && q.size() > 0;
      push = v && q.size() < 2;
      if (pop) last = q.pop_front();
      if (push) q.push_back(d);
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_model();
    chk("reset_data", out_data, RV);
    // asynchronous reset mid-cycle while holding data
    cycle(1, 32'h1234_5678, 0, 0);
    chk("loaded", out_data, 32'h1234_5678);
    #2 rst = 1'b1;
    #1;
    q.delete(); last = RV;
    chk("async_data", out_data, RV);
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_ready", {31'd0, in_ready}, 32'd1);
    chk("async_occ", {30'd0, occupancy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    // streaming
    for (int i = 1; i <= 4; i++) begin
      cycle(1, i, 1, 0);
      chk("stream_data", out_data, i);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
    end
    cycle(0, 0, 1, 0);
    // backpressure
    cycle(1, 32'hA, 0, 0);
    cycle(1, 32'hB, 0, 0);
    chk("bp_occ", {30'd0, occupancy}, 32'd2);
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    cycle(1, 32'hC, 0, 0);
    chk("bp_hold", out_data, 32'hA);
    cycle(1, 32'hC, 1, 0);
    chk("bp_b", out_data, 32'hB);
    cycle(1, 32'hC, 1, 0);
    chk("bp_c", out_data, 32'hC);
    cycle(0, 0, 1, 0);
    chk("bp_empty", {30'd0, occupancy}, 32'd0);
    // flush while full
    cycle(1, 32'hA, 0, 0);
    cycle(1, 32'hB, 0, 0);
    cycle(1, 32'h55, 1, 1);
    chk("fl_occ", {30'd0, occupancy}, 32'd0);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_data", out_data, RV);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    cycle(0, 0, 1, 0);
    chk("fl_no55", out_data, RV);
    // simultaneous in/out while holding one
    cycle(1, 32'h10, 0, 0);
    cycle(1, 32'h20, 1, 0);
    chk("sim_data", out_data, 32'h20);
    chk("sim_occ", {30'd0, occupancy}, 32'd1);
    cycle(0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 10000; i++) begin
      out_ready = ~out_ready;
      #1;
      chk("ready_comb", {31'd0, in_ready}, {31'd0, q.size() < 2});
      cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register for the RISC-V core.
- Generalises the single-bit D flip-flop to a WIDTH-bit payload with valid/ready handshake, a one-entry skid buffer and synchronous flush.
- Sits between core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and decouples backpressure timing: in_ready is a register output, not combinational from out_ready.
- Sustains 1 transfer/cycle.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into both data registers on reset and on flush.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous discard of all held entries (branch mispredict / trap).
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept; registered.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage holds data for downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload to downstream; equals main register.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Transfer rules:
  - In-transfer (IT) = in_valid & in_ready at a rising edge.
  - Out-transfer (OT) = out_valid & out_ready at a rising edge.
  - out_valid/out_data must stay stable while out_valid=1 and out_ready=0.
- Storage: main register (drives out_data) and skid register. State encodes occupancy.
- States and transitions (flush=0):
  - EMPTY (occ 0, out_valid 0, in_ready 1):
    - IT: main<=in_data, go to ONE.
    - No IT: stay.
  - ONE (occ 1, out_valid 1, in_ready 1):
    - IT & OT: main<=in_data, stay in ONE.
    - IT only: skid<=in_data, go to FULL.
    - OT only: go to EMPTY.
    - Neither: stay.
  - FULL (occ 2, out_valid 1, in_ready 0):
    - OT: main<=skid, go to ONE.
    - No OT: stay.
    - IT is impossible because in_ready=0; in_valid is ignored.
- Output decode:
  - in_ready = (state != FULL), registered with the state.
  - out_valid = (state != EMPTY).
  - occupancy = state encoding.
- Latency and throughput:
  - Data accepted at edge N is visible on out_data after edge N (1-cycle latency).
  - Back-to-back IT/OT with out_ready held at 1 gives full throughput with no bubbles.
- Ordering: strict FIFO. Skid data is never presented before main data.
- Flush (synchronous, highest priority over IT/OT):
  - Next state is EMPTY; main and skid both load RESET_VALUE.
  - Any IT or OT in the same cycle is discarded: the input is not stored and the output is not counted as consumed by this block.
  - in_ready=1 on the next cycle.
- Reset (asynchronous, active-high):
  - Immediately forces state EMPTY, main=skid=RESET_VALUE, out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE.
  - Asserting reset mid-transfer loses all held data. Deassertion is synchronous to clk by system convention.
- Data registers load only on the transitions listed above; no enable glitching. X on in_data while in_valid=0 must never reach out_data.

Test Plan:
- Reset with WIDTH=32, RESET_VALUE=32'hDEAD_BEEF: assert rst mid-cycle -> out_data=32'hDEAD_BEEF, out_valid=0, in_ready=1, occupancy=0 immediately, without waiting for a clock edge.
- Streaming with out_ready=1 and in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later, out_valid continuous, occupancy stays 1, in_ready stays 1.
- Backpressure: push 0xA then 0xB while out_ready=0 -> occupancy=2, in_ready=0, out_data holds 0xA. A 0xC presented meanwhile is not accepted. Raise out_ready -> out_data sequence 0xA, 0xB, then 0xC accepted after in_ready returns to 1.
- Flush while FULL (0xA, 0xB held) with in_valid=1, in_data=0x55 in the same cycle -> next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE, 0x55 never appears on the output.
- Simultaneous IT+OT in ONE: main=0x10, in_data=0x20, out_ready=1 -> next cycle out_data=0x20, occupancy=1, skid unused.
- Randomised valid/ready with a scoreboard over 10k cycles -> output sequence matches input order exactly, no loss or duplication, in_ready never combinationally follows out_ready.
